// File: rtl/mtc_output_scheduler_pkg.sv
// Shared defaults and packet type for the MTC output scheduler and its FIFOs.
package mtc_output_scheduler_pkg;

  localparam int MTC_SCHED_N_INPUTS   = 3;
  localparam int MTC_SCHED_FIFO_DEPTH = 4;
  localparam int MTC_SCHED_PKT_WIDTH  = 128;
  localparam int MTC_SCHED_CNT_WIDTH  = 16;

  typedef logic [MTC_SCHED_PKT_WIDTH-1:0] mtc_pkt_t;

  // Source-index width; a single producer still needs one bit to carry the index.
  function automatic int src_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mtc_output_scheduler_if.sv
// Producer-side packet inputs and the SL-link valid/ready output of the scheduler.
interface mtc_output_scheduler_if
  import mtc_output_scheduler_pkg::*;
#(
  parameter int N_INPUTS      = MTC_SCHED_N_INPUTS,
  parameter int MTC_PKT_WIDTH = MTC_SCHED_PKT_WIDTH
) ();

  localparam int SRC_W = src_width(N_INPUTS);

  logic [N_INPUTS*MTC_PKT_WIDTH-1:0] in_data;
  logic [N_INPUTS-1:0]               in_valid;
  logic [MTC_PKT_WIDTH-1:0]          out_data;
  logic [SRC_W-1:0]                  out_src;
  logic                              out_valid;
  logic                              out_ready;

  modport master (
    output in_data, in_valid, out_ready,
    input  out_data, out_src, out_valid
  );

  modport slave (
    input  in_data, in_valid, out_ready,
    output out_data, out_src, out_valid
  );

endinterface

// File: rtl/mtc_sched_fifo.sv
// Per-producer packet FIFO: synchronous write, combinational head, pushes into a full FIFO are dropped.
module mtc_sched_fifo
  import mtc_output_scheduler_pkg::*;
#(
  parameter int WIDTH = MTC_SCHED_PKT_WIDTH,
  parameter int DEPTH = MTC_SCHED_FIFO_DEPTH
) (
  input  logic             clock,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] head,
  output logic             full,
  output logic             empty,
  output logic             drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    cnt_q;
  logic             wr_en, rd_en;

  // Full is taken from the registered count, so a same-cycle pop never rescues a push.
  assign full  = (cnt_q == CW'(DEPTH));
  assign empty = (cnt_q == '0);
  assign head  = mem_q[rd_q];
  assign wr_en = push & ~full;
  assign rd_en = pop & ~empty;
  assign drop  = push & full;

  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (rd_en) rd_q <= rd_q + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) mem_q[wr_q] <= din;
  end

endmodule

// File: rtl/mtc_output_scheduler.sv
// Round-robin scheduler draining N per-producer FIFOs into one registered valid/ready link output,
// with per-input saturating drop counters and sticky overflow flags.
module mtc_output_scheduler
  import mtc_output_scheduler_pkg::*;
#(
  parameter int N_INPUTS      = MTC_SCHED_N_INPUTS,
  parameter int MTC_PKT_WIDTH = MTC_SCHED_PKT_WIDTH,
  parameter int FIFO_DEPTH    = MTC_SCHED_FIFO_DEPTH,
  parameter int CNT_WIDTH     = MTC_SCHED_CNT_WIDTH
) (
  input  logic                          clock,
  input  logic                          rst,
  mtc_output_scheduler_if.slave         bus,
  input  logic                          clear_counters,
  output logic [N_INPUTS-1:0]           fifo_full,
  output logic [N_INPUTS*CNT_WIDTH-1:0] drop_count,
  output logic [N_INPUTS-1:0]           overflow_sticky
);

  localparam int SRC_W = src_width(N_INPUTS);

  logic [MTC_PKT_WIDTH-1:0] head [N_INPUTS];
  logic [N_INPUTS-1:0]      empty, full, drop, pop;

  logic [SRC_W-1:0]         rr_q, rr_d, grant, src_q;
  logic [MTC_PKT_WIDTH-1:0] grant_data, data_q;
  logic                     grant_vld, valid_q, load;
  logic [CNT_WIDTH-1:0]     cnt_q [N_INPUTS];
  logic [N_INPUTS-1:0]      sticky_q;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  for (genvar g = 0; g < N_INPUTS; g++) begin : g_fifo
    mtc_sched_fifo #(
      .WIDTH (MTC_PKT_WIDTH),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clock (clock),
      .rst   (rst),
      .push  (bus.in_valid[g]),
      .pop   (pop[g]),
      .din   (bus.in_data[g*MTC_PKT_WIDTH +: MTC_PKT_WIDTH]),
      .head  (head[g]),
      .full  (full[g]),
      .empty (empty[g]),
      .drop  (drop[g])
    );
    assign drop_count[g*CNT_WIDTH +: CNT_WIDTH] = cnt_q[g];
  end

  // Grant the non-empty FIFO at the smallest distance above the RR pointer.
  always_comb begin
    int best;
    int off;
    best       = N_INPUTS;
    off        = 0;
    grant      = rr_q;
    grant_data = head[0];
    for (int i = 0; i < N_INPUTS; i++) begin
      off = (i + N_INPUTS - int'(rr_q)) % N_INPUTS;
      if (!empty[i] && off < best) begin
        best       = off;
        grant      = SRC_W'(i);
        grant_data = head[i];
      end
    end
  end

  assign grant_vld = ~&empty;
  assign load      = (~valid_q | bus.out_ready) & grant_vld;
  assign rr_d      = (int'(grant) == N_INPUTS - 1) ? '0 : grant + 1'b1;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N_INPUTS; i++) begin
      pop[i] = load && (grant == SRC_W'(i));
    end
  end

  // Output register stage
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      rr_q    <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      src_q   <= '0;
    end else if (load) begin
      rr_q    <= rr_d;
      valid_q <= 1'b1;
      data_q  <= grant_data;
      src_q   <= grant;
    end else if (bus.out_ready) begin
      valid_q <= 1'b0;
    end
  end

  // Clear has priority over a coincident drop.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= '0;
      sticky_q <= '0;
    end else if (clear_counters) begin
      for (int i = 0; i < N_INPUTS; i++) cnt_q[i] <= '0;
      sticky_q <= '0;
    end else begin
      for (int i = 0; i < N_INPUTS; i++) begin
        if (drop[i]) begin
          cnt_q[i]    <= sat_inc(cnt_q[i]);
          sticky_q[i] <= 1'b1;
        end
      end
    end
  end

  assign bus.out_valid   = valid_q;
  assign bus.out_data    = data_q;
  assign bus.out_src     = src_q;
  assign fifo_full       = full;
  assign overflow_sticky = sticky_q;

endmodule

// File: tb/tb_mtc_output_scheduler.sv
// Bench for mtc_output_scheduler: directed scenarios plus random traffic against a queue-based reference model.
module tb_mtc_output_scheduler;
  import mtc_output_scheduler_pkg::*;

  localparam int N   = 3;
  localparam int W   = 128;
  localparam int D   = 4;
  localparam int CW  = 4;
  localparam int SAT = (1 << CW) - 1;

  logic          clock = 1'b0;
  logic          rst;
  logic          clear_counters;
  logic [N-1:0]  fifo_full, overflow_sticky;
  logic [N*CW-1:0] drop_count;

  always #5 clock = ~clock;

  mtc_output_scheduler_if #(.N_INPUTS(N), .MTC_PKT_WIDTH(W)) bus ();

  mtc_output_scheduler #(
    .N_INPUTS(N), .MTC_PKT_WIDTH(W), .FIFO_DEPTH(D), .CNT_WIDTH(CW)
  ) dut (
    .clock           (clock),
    .rst             (rst),
    .bus             (bus),
    .clear_counters  (clear_counters),
    .fifo_full       (fifo_full),
    .drop_count      (drop_count),
    .overflow_sticky (overflow_sticky)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: one queue per input plus the presented packet.
  mtc_pkt_t mq [N][$];
  int       m_rr, m_os;
  bit       m_ov;
  mtc_pkt_t m_od;
  int       m_cnt [N];
  bit       m_st  [N];

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic mtc_pkt_t rnd_pkt();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mq[i].delete();
      m_cnt[i] = 0;
      m_st[i]  = 0;
    end
    m_rr = 0; m_os = 0; m_ov = 0; m_od = '0;
  endtask

  task automatic model_step(input logic [N-1:0] v, input mtc_pkt_t d0, input mtc_pkt_t d1,
                            input mtc_pkt_t d2, input bit rdy, input bit clr);
    mtc_pkt_t d [N];
    int       pre [N];
    bit       found;
    int       idx;
    d[0] = d0; d[1] = d1; d[2] = d2;
    for (int i = 0; i < N; i++) pre[i] = mq[i].size();
    if (!m_ov || rdy) begin
      found = 0;
      for (int k = 0; k < N; k++) begin
        idx = (m_rr + k) % N;
        if (!found && pre[idx] > 0) begin
          found = 1;
          m_od  = mq[idx].pop_front();
          m_os  = idx;
          m_ov  = 1;
          m_rr  = (idx + 1) % N;
        end
      end
      if (!found && rdy) m_ov = 0;
    end
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        if (pre[i] >= D) begin
          if (m_cnt[i] < SAT) m_cnt[i]++;
          m_st[i] = 1;
        end else begin
          mq[i].push_back(d[i]);
        end
      end
    end
    if (clr) begin
      for (int i = 0; i < N; i++) begin
        m_cnt[i] = 0;
        m_st[i]  = 0;
      end
    end
  endtask

  task automatic check_all();
    chk("out_valid", 128'(bus.out_valid), 128'(m_ov));
    chk("out_data",  bus.out_data, m_od);
    chk("out_src",   128'(bus.out_src), 128'(m_os));
    for (int i = 0; i < N; i++) begin
      chk($sformatf("fifo_full%0d", i), 128'(fifo_full[i]), 128'(mq[i].size() == D));
      chk($sformatf("drop_count%0d", i), 128'(drop_count[i*CW +: CW]), 128'(m_cnt[i]));
      chk($sformatf("sticky%0d", i), 128'(overflow_sticky[i]), 128'(m_st[i]));
    end
  endtask

  task automatic cycle(input logic [N-1:0] v, input mtc_pkt_t d0, input mtc_pkt_t d1,
                       input mtc_pkt_t d2, input bit rdy, input bit clr);
    @(negedge clock);
    bus.in_valid   = v;
    bus.in_data    = {d2, d1, d0};
    bus.out_ready  = rdy;
    clear_counters = clr;
    model_step(v, d0, d1, d2, rdy, clr);
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic idle(input bit rdy);
    cycle('0, '0, '0, '0, rdy, 1'b0);
  endtask

  task automatic zero_checks(input string tag);
    chk({tag, "_valid"},  128'(bus.out_valid), '0);
    chk({tag, "_data"},   bus.out_data, '0);
    chk({tag, "_src"},    128'(bus.out_src), '0);
    chk({tag, "_full"},   128'(fifo_full), '0);
    chk({tag, "_drops"},  128'(drop_count), '0);
    chk({tag, "_sticky"}, 128'(overflow_sticky), '0);
  endtask

  initial begin
    mtc_pkt_t a5, p;
    int       exp_src [3];
    a5 = {16{8'hA5}};

    rst = 1'b0; clear_counters = 1'b0;
    bus.in_valid = '0; bus.in_data = '0; bus.out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clock);
    #1;
    zero_checks("reset");
    @(negedge clock);
    rst = 1'b1;

    // Single packet: two-edge latency, drops out after acceptance.
    cycle(3'b010, '0, a5, '0, 1'b1, 1'b0);
    chk("single_lat", 128'(bus.out_valid), 128'(0));
    idle(1'b1);
    chk("single_valid", 128'(bus.out_valid), 128'(1));
    chk("single_data", bus.out_data, a5);
    chk("single_src", 128'(bus.out_src), 128'(1));
    idle(1'b1);
    chk("single_done", 128'(bus.out_valid), 128'(0));

    // Round robin from pointer 2 (after serving input 1) and then from 0 again.
    cycle(3'b111, rnd_pkt(), rnd_pkt(), rnd_pkt(), 1'b1, 1'b0);
    exp_src = '{2, 0, 1};
    for (int j = 0; j < 3; j++) begin
      idle(1'b1);
      chk($sformatf("rr_a%0d", j), 128'(bus.out_src), 128'(exp_src[j]));
    end
    idle(1'b1);
    cycle(3'b111, rnd_pkt(), rnd_pkt(), rnd_pkt(), 1'b1, 1'b0);
    exp_src = '{2, 0, 1};
    for (int j = 0; j < 3; j++) begin
      idle(1'b1);
      chk($sformatf("rr_b%0d", j), 128'(bus.out_src), 128'(exp_src[j]));
    end
    repeat (2) idle(1'b1);

    // Backpressure: hold a presented packet while input 0 overfills.
    p = rnd_pkt();
    cycle(3'b010, '0, p, '0, 1'b1, 1'b0);
    idle(1'b1);
    for (int j = 0; j < 6; j++) cycle(3'b001, rnd_pkt(), '0, '0, 1'b0, 1'b0);
    repeat (4) idle(1'b0);
    chk("bp_data", bus.out_data, p);
    chk("bp_src", 128'(bus.out_src), 128'(1));
    chk("bp_full0", 128'(fifo_full[0]), 128'(1));
    chk("bp_drops0", 128'(drop_count[0 +: CW]), 128'(2));
    chk("bp_sticky0", 128'(overflow_sticky[0]), 128'(1));

    // Full FIFO with a coincident pop still drops the push.
    cycle(3'b001, rnd_pkt(), '0, '0, 1'b1, 1'b0);
    chk("fullpop_drops0", 128'(drop_count[0 +: CW]), 128'(3));

    // Saturation, then clear coincident with a drop.
    for (int j = 0; j < 22; j++) cycle(3'b001, rnd_pkt(), '0, '0, 1'b0, 1'b0);
    chk("sat_drops0", 128'(drop_count[0 +: CW]), 128'(SAT));
    cycle(3'b001, rnd_pkt(), '0, '0, 1'b0, 1'b1);
    chk("clr_drops0", 128'(drop_count[0 +: CW]), 128'(0));
    chk("clr_sticky0", 128'(overflow_sticky[0]), 128'(0));
    cycle(3'b001, rnd_pkt(), '0, '0, 1'b0, 1'b0);
    chk("post_clr_drops0", 128'(drop_count[0 +: CW]), 128'(1));
    repeat (8) idle(1'b1);

    // Random traffic.
    for (int j = 0; j < 400; j++) begin
      cycle(N'($urandom_range(0, 7)), rnd_pkt(), rnd_pkt(), rnd_pkt(),
            $urandom_range(0, 9) < 7, $urandom_range(0, 49) == 0);
    end

    // Asynchronous reset mid-operation.
    cycle(3'b111, rnd_pkt(), rnd_pkt(), rnd_pkt(), 1'b0, 1'b0);
    cycle(3'b111, rnd_pkt(), rnd_pkt(), rnd_pkt(), 1'b0, 1'b0);
    chk("pre_rst_valid", 128'(bus.out_valid), 128'(1));
    #2;
    rst = 1'b0;
    #1;
    zero_checks("midrst");
    model_reset();
    @(negedge clock);
    bus.in_valid  = '0;
    bus.out_ready = 1'b1;
    @(negedge clock);
    rst = 1'b1;
    repeat (5) idle(1'b1);
    for (int j = 0; j < 50; j++) begin
      cycle(N'($urandom_range(0, 7)), rnd_pkt(), rnd_pkt(), rnd_pkt(),
            $urandom_range(0, 9) < 6, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
